// File: rtl/datapath_pkg.sv
// Shared widths, IR field positions, condition codes and ALU op bundle
// for the datapath slice.
package datapath_pkg;

    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 16;
    localparam int RAM_DEPTH = 512;
    localparam int ADDR_W    = 9;
    localparam int IDX_W     = 4;

    localparam int RA_HI   = 26;
    localparam int RA_LO   = 23;
    localparam int RB_HI   = 22;
    localparam int RB_LO   = 19;
    localparam int RC_HI   = 18;
    localparam int RC_LO   = 15;
    localparam int C_HI    = 18;
    localparam int COND_HI = 20;
    localparam int COND_LO = 19;

    typedef enum logic [1:0] {
        COND_ZERO = 2'b00,
        COND_NZ   = 2'b01,
        COND_POS  = 2'b10,
        COND_NEG  = 2'b11
    } cond_e;

    typedef struct packed {
        logic add;
        logic sub;
        logic mul;
        logic div;
        logic and_op;
        logic or_op;
        logic shr;
        logic shra;
        logic shl;
        logic ror;
        logic rol;
        logic neg;
        logic not_op;
        logic inc_pc;
    } alu_op_t;

    // Positive means strictly greater than zero as a signed value.
    function automatic logic cond_met(cond_e c, logic [DATA_W-1:0] v);
        unique case (c)
            COND_ZERO: cond_met = (v == '0);
            COND_NZ:   cond_met = (v != '0);
            COND_POS:  cond_met = !v[DATA_W-1] && (v != '0);
            COND_NEG:  cond_met = v[DATA_W-1];
        endcase
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// 64-bit result ALU: A comes from Y, B from the bus; first selected
// operation in the op bundle wins.
module alu
    import datapath_pkg::*;
(
    input  alu_op_t             op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [2*DATA_W-1:0] result
);

    logic [4:0]            sh;
    logic [2*DATA_W-1:0]   prod;
    logic [2*DATA_W-1:0]   ror_w;
    logic [2*DATA_W-1:0]   rol_w;
    logic [DATA_W-1:0]     quot;
    logic [DATA_W-1:0]     rem;

    assign sh = b[4:0];
    assign prod = $signed({{DATA_W{a[DATA_W-1]}}, a})
                * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign ror_w = {a, a} >> sh;
    assign rol_w = {a, a} << sh;

    always_comb begin
        quot = '0;
        rem  = '0;
        if (b != '0) begin
            quot = $signed(a) / $signed(b);
            rem  = $signed(a) % $signed(b);
        end
    end

    always_comb begin
        result = '0;
        if (op.add)         result = {32'h0, a + b};
        else if (op.sub)    result = {32'h0, a - b};
        else if (op.mul)    result = prod;
        else if (op.div)    result = {rem, quot};
        else if (op.and_op) result = {32'h0, a & b};
        else if (op.or_op)  result = {32'h0, a | b};
        else if (op.shr)    result = {32'h0, a >> sh};
        else if (op.shra)   result = {32'h0, $signed(a) >>> sh};
        else if (op.shl)    result = {32'h0, a << sh};
        else if (op.ror)    result = {32'h0, ror_w[DATA_W-1:0]};
        else if (op.rol)    result = {32'h0, rol_w[2*DATA_W-1:DATA_W]};
        else if (op.neg)    result = {32'h0, 32'h0 - b};
        else if (op.not_op) result = {32'h0, ~b};
        else if (op.inc_pc) result = {32'h0, b + 32'd1};
    end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, special registers, bus mux,
// register select logic, condition flip-flop and 512x32 RAM.
module datapath
    import datapath_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              HIin, LOin, Zhighin, Zlowin, PCin,
    input  logic              MDRin, MARin, IRin, Yin, OutPortin,
    input  logic              HIout, LOout, Zhighout, Zlowout, PCout,
    input  logic              MDRout, InPortout, CSEout,
    input  logic              MDMuxread,
    input  logic              ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA,
    input  logic              SHL, ROR, ROL, NEG, NOT, IncPC,
    input  logic              Gra, Grb, Grc,
    input  logic              Rin, Rout, BAout,
    input  logic [DATA_W-1:0] InPortdata,
    input  logic              RAMread, RAMwrite,
    output logic [DATA_W-1:0] OutPortdata,
    output logic              ConFFQ
);

    logic [DATA_W-1:0]   r [NUM_REGS];
    logic [DATA_W-1:0]   hi, lo, pc, ir, mdr, y, in_port, out_port;
    logic [2*DATA_W-1:0] z;
    logic [ADDR_W-1:0]   mar;
    logic                con_ff;
    logic [DATA_W-1:0]   mem [RAM_DEPTH];

    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   bus, cse, ram_data, mdr_d;
    logic [2*DATA_W-1:0] alu_res;
    alu_op_t             alu_op;
    logic                unused_opcode;

    // Opcode bits are decoded by the control unit, not here.
    assign unused_opcode = ^ir[31:27];

    always_comb begin
        idx = '0;
        if (Gra)      idx = ir[RA_HI:RA_LO];
        else if (Grb) idx = ir[RB_HI:RB_LO];
        else if (Grc) idx = ir[RC_HI:RC_LO];
    end

    assign cse = {{(DATA_W-C_HI-1){ir[C_HI]}}, ir[C_HI:0]};

    always_comb begin
        bus = '0;
        if (Rout)           bus = r[idx];
        else if (BAout)     bus = (idx == '0) ? '0 : r[idx];
        else if (HIout)     bus = hi;
        else if (LOout)     bus = lo;
        else if (Zhighout)  bus = z[2*DATA_W-1:DATA_W];
        else if (Zlowout)   bus = z[DATA_W-1:0];
        else if (PCout)     bus = pc;
        else if (MDRout)    bus = mdr;
        else if (InPortout) bus = in_port;
        else if (CSEout)    bus = cse;
    end

    assign ram_data = RAMread ? mem[mar] : '0;
    assign mdr_d    = MDMuxread ? ram_data : bus;

    assign alu_op = {ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA,
                     SHL, ROR, ROL, NEG, NOT, IncPC};

    alu u_alu (
        .op     (alu_op),
        .a      (y),
        .b      (bus),
        .result (alu_res)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) r[i] <= '0;
            hi       <= '0;
            lo       <= '0;
            pc       <= '0;
            ir       <= '0;
            mar      <= '0;
            mdr      <= '0;
            y        <= '0;
            z        <= '0;
            in_port  <= '0;
            out_port <= '0;
            con_ff   <= 1'b0;
        end else begin
            if (Rin)       r[idx] <= bus;
            if (HIin)      hi <= bus;
            if (LOin)      lo <= bus;
            if (PCin)      pc <= bus;
            if (IRin)      ir <= bus;
            if (MARin)     mar <= bus[ADDR_W-1:0];
            if (MDRin)     mdr <= mdr_d;
            if (Yin)       y <= bus;
            if (Zlowin)    z[DATA_W-1:0] <= alu_res[DATA_W-1:0];
            if (Zhighin)   z[2*DATA_W-1:DATA_W] <= alu_res[2*DATA_W-1:DATA_W];
            if (OutPortin) out_port <= bus;
            if (Gra && Rout)
                con_ff <= cond_met(cond_e'(ir[COND_HI:COND_LO]), bus);
            in_port <= InPortdata;
        end
    end

    // Memory keeps its contents across clear.
    always_ff @(posedge clock) begin
        if (RAMwrite) mem[mar] <= mdr;
    end

    assign OutPortdata = out_port;
    assign ConFFQ      = con_ff;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: expected OutPort/ConFF values are queued
// with the driving cycle and compared after that cycle's edge.
module tb_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic        HIin, LOin, Zhighin, Zlowin, PCin;
    logic        MDRin, MARin, IRin, Yin, OutPortin;
    logic        HIout, LOout, Zhighout, Zlowout, PCout;
    logic        MDRout, InPortout, CSEout, MDMuxread;
    logic        ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA;
    logic        SHL, ROR, ROL, NEG, NOT, IncPC;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic [31:0] InPortdata;
    logic        RAMread, RAMwrite;
    logic [31:0] OutPortdata;
    logic        ConFFQ;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        bit          is_cff;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];

    datapath dut (
        .clock(clock), .clear(clear),
        .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .PCin(PCin), .MDRin(MDRin), .MARin(MARin), .IRin(IRin),
        .Yin(Yin), .OutPortin(OutPortin),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .PCout(PCout), .MDRout(MDRout),
        .InPortout(InPortout), .CSEout(CSEout), .MDMuxread(MDMuxread),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .AND(AND), .OR(OR),
        .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL),
        .NEG(NEG), .NOT(NOT), .IncPC(IncPC),
        .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .InPortdata(InPortdata), .RAMread(RAMread), .RAMwrite(RAMwrite),
        .OutPortdata(OutPortdata), .ConFFQ(ConFFQ)
    );

    always #5 clock = ~clock;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        {HIin, LOin, Zhighin, Zlowin, PCin} = '0;
        {MDRin, MARin, IRin, Yin, OutPortin} = '0;
        {HIout, LOout, Zhighout, Zlowout, PCout} = '0;
        {MDRout, InPortout, CSEout, MDMuxread} = '0;
        {ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA} = '0;
        {SHL, ROR, ROL, NEG, NOT, IncPC} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
        {RAMread, RAMwrite} = '0;
    endtask

    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.is_cff) check(e.tag, {31'h0, ConFFQ}, e.exp);
            else          check(e.tag, OutPortdata, e.exp);
        end
        idle();
    endtask

    task automatic expect_out(string tag, logic [31:0] v);
        sbq.push_back('{tag, 1'b0, v});
        OutPortin = 1'b1;
    endtask

    task automatic expect_cff(string tag, logic v);
        sbq.push_back('{tag, 1'b1, {31'h0, v}});
    endtask

    // InPort registers its data one edge before it can drive the bus.
    task automatic put(logic [31:0] v);
        InPortdata = v;
        step();
        InPortout = 1'b1;
    endtask

    task automatic write_mem(logic [31:0] a, logic [31:0] d);
        put(a); MARin = 1'b1; step();
        put(d); MDRin = 1'b1; step();
        RAMwrite = 1'b1; step();
    endtask

    task automatic fetch(bit clr_mid);
        PCout = 1; MARin = 1; IncPC = 1; Zlowin = 1; step();
        Zlowout = 1; PCin = 1; RAMread = 1; MDMuxread = 1; MDRin = 1;
        clear = clr_mid;
        step();
        clear = 1'b0;
        if (!clr_mid) begin
            MDRout = 1; IRin = 1; step();
        end
    endtask

    task automatic show_pc(string tag, logic [31:0] v);
        PCout = 1'b1; expect_out(tag, v); step();
    endtask

    task automatic show_ra(string tag, logic [31:0] v);
        Gra = 1'b1; Rout = 1'b1; expect_out(tag, v); step();
    endtask

    task automatic set_op(int code);
        case (code)
            0:  ADD = 1;
            1:  SUB = 1;
            2:  MUL = 1;
            3:  DIV = 1;
            4:  AND = 1;
            5:  OR = 1;
            6:  SHR = 1;
            7:  SHRA = 1;
            8:  SHL = 1;
            9:  ROR = 1;
            10: ROL = 1;
            11: NEG = 1;
            12: NOT = 1;
            13: IncPC = 1;
            14: begin ADD = 1; SUB = 1; MUL = 1; end
            default: ;
        endcase
    endtask

    task automatic alu_case(string tag, int code, logic [31:0] yv,
                            bit drive_b, logic [31:0] bv,
                            logic [31:0] lo, bit chk_hi,
                            logic [31:0] hi);
        put(yv); Yin = 1'b1; step();
        if (drive_b) put(bv);
        set_op(code); Zlowin = 1; Zhighin = 1; step();
        Zlowout = 1'b1; expect_out({tag, "_lo"}, lo); step();
        if (chk_hi) begin
            Zhighout = 1'b1; expect_out({tag, "_hi"}, hi); step();
        end
    endtask

    initial begin
        idle();
        InPortdata = '0;
        clear = 1'b1;
        step();
        step();
        clear = 1'b0;

        check("rst_out", OutPortdata, 32'h0);
        check("rst_cff", {31'h0, ConFFQ}, 32'h0);
        show_pc("rst_pc", 32'h0);

        write_mem(32'h000, 32'h0300_00F1);
        write_mem(32'h001, 32'h0378_0000);
        write_mem(32'h0F1, 32'h0780_0000);

        fetch(1'b0);
        Grb = 1; BAout = 1; Yin = 1; step();
        CSEout = 1; ADD = 1; Zlowin = 1; step();
        Zlowout = 1; Gra = 1; Rin = 1; step();
        show_ra("ldi_r6", 32'h0000_00F1);
        show_pc("ldi_pc", 32'h1);

        fetch(1'b0);
        PCout = 1; Grb = 1; Rin = 1; step();
        Gra = 1; Rout = 1; PCin = 1; step();
        Grb = 1; Rout = 1; expect_out("jal_r15", 32'h2); step();
        show_pc("jal_pc", 32'hF1);

        fetch(1'b0);
        Gra = 1; Rout = 1; PCin = 1; step();
        show_pc("jr_pc", 32'h2);

        alu_case("div0", 3, 32'd7, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        alu_case("div", 3, 32'hFFFF_FFF9, 1'b1, 32'd2,
                 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF);
        alu_case("shra", 7, 32'h8000_0000, 1'b1, 32'd1,
                 32'hC000_0000, 1'b0, 32'h0);
        alu_case("rol", 10, 32'h8000_0001, 1'b1, 32'd1,
                 32'h0000_0003, 1'b0, 32'h0);
        alu_case("ror", 9, 32'h0000_0001, 1'b1, 32'd1,
                 32'h8000_0000, 1'b0, 32'h0);
        alu_case("shr", 6, 32'h8000_0000, 1'b1, 32'd4,
                 32'h0800_0000, 1'b0, 32'h0);
        alu_case("shl", 8, 32'h0000_0001, 1'b1, 32'd31,
                 32'h8000_0000, 1'b0, 32'h0);
        alu_case("mul", 2, 32'hFFFF_FFFD, 1'b1, 32'd5,
                 32'hFFFF_FFF1, 1'b1, 32'hFFFF_FFFF);
        alu_case("sub", 1, 32'd5, 1'b1, 32'd7,
                 32'hFFFF_FFFE, 1'b1, 32'h0);
        alu_case("prio", 14, 32'd5, 1'b1, 32'd7,
                 32'd12, 1'b1, 32'h0);
        alu_case("neg", 11, 32'd9, 1'b1, 32'd1,
                 32'hFFFF_FFFF, 1'b1, 32'h0);
        alu_case("and", 4, 32'hF0F0_1234, 1'b1, 32'h0FF0_FF00,
                 32'h00F0_1200, 1'b1, 32'h0);
        alu_case("none", 15, 32'd5, 1'b1, 32'd7,
                 32'h0, 1'b1, 32'h0);

        put(32'h0308_0000); IRin = 1; step();
        Gra = 1; Rout = 1; expect_cff("cff_nz", 1'b1); step();
        put(32'h0300_0000); IRin = 1; step();
        Gra = 1; Rout = 1; expect_cff("cff_zero", 1'b0); step();
        put(32'h0310_0000); IRin = 1; step();
        Gra = 1; Rout = 1; expect_cff("cff_pos", 1'b1); step();
        put(32'h0318_0000); IRin = 1; step();
        Gra = 1; Rout = 1; expect_cff("cff_neg", 1'b0); step();
        put(32'h0310_0000); IRin = 1; step();
        Gra = 1; Rout = 1; step();

        fetch(1'b1);
        check("clr_out", OutPortdata, 32'h0);
        check("clr_cff", {31'h0, ConFFQ}, 32'h0);
        show_pc("clr_pc", 32'h0);
        expect_out("empty_bus", 32'h0); step();
        put(32'h0300_0000); IRin = 1; step();
        show_ra("clr_r6", 32'h0);

        fetch(1'b0);
        CSEout = 1; expect_out("ram_kept", 32'hF1); step();
        show_pc("refetch_pc", 32'h1);

        Zlowout = 1; IncPC = 1; Zlowin = 1;
        expect_out("rd_old_z", 32'h1); step();
        Zlowout = 1; expect_out("rd_new_z", 32'h2); step();

        check("sb_empty", sbq.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clock  in  1  single system clock; all state updates occur on its rising edge.
REQ-002 clear  in  1  reset: synchronous, active-high.
REQ-003 HIin, LOin, Zhighin, Zlowin, PCin, MDRin, MARin, IRin, Yin, OutPortin  in  1 each  register load enables from the bus or the ALU.
REQ-004 HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, CSEout  in  1 each  bus source selects.
REQ-005 MDMuxread  in  1  MDR input select: 1 = RAM read data, 0 = bus.
REQ-006 ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC  in  1 each  ALU operation selects.
REQ-007 Gra, Grb, Grc  in  1 each  choose IR field Ra[26:23], Rb[22:19] or Rc[18:15] as the register index.
REQ-008 Rin, Rout, BAout  in  1 each  write, read, or base-address-read of the selected general register.
REQ-009 InPortdata  in  32  external input port data.
REQ-010 RAMread, RAMwrite  in  1 each  memory read and write strobes.
REQ-011 OutPortdata  out  32  contents of the OutPort register.
REQ-012 ConFFQ  out  1  condition flip-flop output.

Function
REQ-013 The block SHALL contain a 32-bit shared bus, R0-R15, HI, LO, PC, IR, MAR (9 bit), MDR, Y, a 64-bit Z, InPort, OutPort, and a 512x32 RAM.
REQ-014 Bus source priority: R(sel) via Rout/BAout, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C. If no source is selected, the bus SHALL be 0.
REQ-015 Register index = Ra if Gra, else Rb if Grb, else Rc if Grc, else 0. Rin SHALL load the bus into R[index] at the clock edge.
REQ-016 BAout SHALL drive 0 when index = 0; otherwise it SHALL drive R[index]. Rout SHALL always drive R[index].
REQ-017 CSEout SHALL drive IR[18:0], sign-extended to 32 bits.
REQ-018 The ALU SHALL take A = Y and B = bus, and its result SHALL be 64 bits (see REQ-019 to REQ-022). Zlowin loads result[31:0]; Zhighin loads result[63:32].
REQ-019 ADD and SUB SHALL compute A+B and A-B modulo 2^32. AND, OR and NOT (on B) are bitwise. NEG SHALL compute 0-B. IncPC SHALL compute B+1. All of these SHALL set the high result half to 0.
REQ-020 MUL SHALL produce the signed 64-bit product of A and B.
REQ-021 DIV SHALL produce the signed quotient in the low half and the remainder in the high half. When B = 0, the whole result SHALL be 0.
REQ-022 SHR, SHRA and SHL SHALL shift A by B[4:0]. ROR and ROL SHALL rotate A by B[4:0].
REQ-023 ALU priority SHALL follow the order listed in REQ-006. With no operation selected, the result SHALL be 0.
REQ-024 MARin SHALL load bus[8:0] into MAR.
REQ-025 RAM read SHALL be combinational at address MAR, so that RAMread, MDMuxread and MDRin asserted in one cycle capture mem[MAR] at that cycle's edge.
REQ-026 RAMwrite SHALL write MDR into mem[MAR] at the clock edge. Simultaneous RAMread and RAMwrite SHALL read the old data.
REQ-027 InPort SHALL capture InPortdata on every edge. OutPortin SHALL load the bus into OutPort.
REQ-028 ConFF SHALL load on any edge where Gra and Rout are both asserted. Condition IR[20:19] applied to the bus value: 00 = zero, 01 = nonzero, 10 = positive, 11 = negative.
REQ-029 All registers SHALL hold their value when their load enable is low. A register load and a read of the same register in one cycle SHALL read the pre-edge value.

Reset
REQ-030 While clear is sampled high at a rising edge, R0-R15, HI, LO, PC, IR, MAR, MDR, Y, Z, InPort, OutPort and ConFF SHALL become 0 and all loads that cycle SHALL be ignored. OutPortdata = 0 and ConFFQ = 0 after reset.
REQ-031 RAM contents SHALL NOT be affected by clear; RAM SHALL be initialised from a hex image at simulation start.
REQ-032 Asserting clear mid-instruction SHALL abort it: PC = 0 and the next fetch starts at address 0.

Structure
REQ-033 A shared package SHALL hold: data width 32, register count 16, RAM depth 512, IR field bit positions, and condition codes.
REQ-034 The ALU SHALL be one sub-module, alu. Registers, bus multiplexer, select/encode logic and RAM stay in datapath.

Verification
REQ-035 RAM[0] = {Ra=6, Rb=0, C=0xF1}; run fetch then Grb+BAout+Yin, CSEout+ADD+Zlowin, Zlowout+Gra+Rin -> R6 = 0xF1, PC = 1.
REQ-036 RAM[1] = {Ra=6, Rb=15}; run fetch then PCout+Grb+Rin, Gra+Rout+PCin -> R15 = 2, PC = 0xF1.
REQ-037 RAM[0xF1] = {Ra=15}; run fetch then Gra+Rout+PCin -> PC = 2.
REQ-038 Y = 7, bus = 0 with DIV -> Z = 0. Y = -7, bus = 2 with DIV -> Zlow = -3, Zhigh = -1.
REQ-039 Y = 0x80000000, bus = 1 with SHRA -> Zlow = 0xC0000000. Y = 0x80000001, bus = 1 with ROL -> Zlow = 0x00000003.
REQ-040 Assert clear during the MDRin fetch cycle -> all registers are 0 and the RAM image is unchanged.
